// File: rtl/uart_tx.sv
// uart_tx: LSB-first UART transmitter paced by an external one-cycle baud tick.
// Define UART_TX_PARITY_EN to insert a parity bit between the data and stop bits.
module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_bd,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_done
);
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, WAIT, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, WAIT, START, DATA, STOP} state_t;
`endif
    state_t               state, state_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [2:0]           cnt, cnt_n;
    logic                 tx_n, ready_n, busy_n, done_n;
`ifdef UART_TX_PARITY_EN
    logic                 par, par_n;
`else
    logic                 unused_parity;
    assign unused_parity = 1'(PARITY_ODD);
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            shift   <= '0;
            cnt     <= '0;
            o_tx    <= 1'b1;
            o_ready <= 1'b1;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            shift   <= shift_n;
            cnt     <= cnt_n;
            o_tx    <= tx_n;
            o_ready <= ready_n;
            o_busy  <= busy_n;
            o_done  <= done_n;
`ifdef UART_TX_PARITY_EN
            par     <= par_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        shift_n = shift;
        cnt_n   = cnt;
        tx_n    = o_tx;
        ready_n = o_ready;
        busy_n  = o_busy;
        done_n  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n   = par;
`endif
        case (state)
            IDLE: if (i_valid && o_ready) begin
                shift_n = i_data;
                cnt_n   = '0;
                ready_n = 1'b0;
                busy_n  = 1'b1;
                state_n = WAIT;
`ifdef UART_TX_PARITY_EN
                par_n   = 1'b0;
`endif
            end
            // Start bit waits for a tick so every bit lasts a full tick period
            WAIT: if (i_bd) begin
                tx_n    = 1'b0;
                state_n = START;
            end
            START: if (i_bd) begin
                tx_n    = shift[0];
                shift_n = shift >> 1;
                state_n = DATA;
`ifdef UART_TX_PARITY_EN
                par_n   = par ^ shift[0];
`endif
            end
            DATA: if (i_bd) begin
                if (cnt < 3'(DATA_BITS - 1)) begin
                    tx_n    = shift[0];
                    shift_n = shift >> 1;
                    cnt_n   = cnt + 3'd1;
`ifdef UART_TX_PARITY_EN
                    par_n   = par ^ shift[0];
`endif
                end else begin
                    cnt_n   = '0;
`ifdef UART_TX_PARITY_EN
                    tx_n    = par ^ 1'(PARITY_ODD);
                    state_n = PARITY;
`else
                    tx_n    = 1'b1;
                    state_n = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (i_bd) begin
                tx_n    = 1'b1;
                state_n = STOP;
            end
`endif
            STOP: if (i_bd) begin
                if (cnt == 3'(STOP_BITS - 1)) begin
                    cnt_n   = '0;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    ready_n = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 3'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx; expected line bits are queued at
// acceptance and popped by a monitor that samples o_tx after every baud tick.
module tb_uart_tx;
`ifdef UART_TX_PARITY_EN
    localparam int SB = 2;
    localparam int PB = 1;
`else
    localparam int SB = 1;
    localparam int PB = 0;
`endif
    localparam int PODD = 0;
    localparam int FL   = 1 + 8 + PB + SB;
    localparam int LIM  = 4000;

    logic       clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_bd = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       i_valid = 1'b0;
    logic       o_ready, o_tx, o_busy, o_done;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   tc = 0;
    int   tick_n = 0;
    int   mon_idx = 0;
    logic bd_s, exp_done, e;
    logic exp_q[$];
    int   starts_q[$];
    int   dones_q[$];

    uart_tx #(.DATA_BITS(8), .STOP_BITS(SB), .PARITY_ODD(PODD)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_bd(i_bd), .i_data(i_data), .i_valid(i_valid),
        .o_ready(o_ready), .o_tx(o_tx), .o_busy(o_busy), .o_done(o_done)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        i_bd = (tc == 15);
        tc = (tc + 1) % 16;
    end

    // Monitor: frame bits are sampled just after each tick edge
    initial forever begin
        @(posedge clk);
        bd_s = i_bd;
        #1;
        if (!i_rst_n) begin
            mon_idx = 0;
            exp_q.delete();
        end else begin
            exp_done = 1'b0;
            if (bd_s) begin
                tick_n++;
                if (mon_idx == FL) begin
                    exp_done = 1'b1;
                    mon_idx = 0;
                    dones_q.push_back(tick_n);
                end else if (mon_idx > 0 || o_tx === 1'b0) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL tx_unexpected: bit %0d o_tx=%b with nothing queued", mon_idx, o_tx);
                    end else begin
                        e = exp_q.pop_front();
                        if (o_tx !== e) begin
                            n_bad++;
                            $display("FAIL tx_bit%0d: o_tx=%b required %b", mon_idx, o_tx, e);
                        end
                    end
                    if (mon_idx == 0) starts_q.push_back(tick_n);
                    mon_idx++;
                end
            end
            n_cmp++;
            if (o_done !== exp_done) begin
                n_bad++;
                $display("FAIL done_pulse: o_done=%b required %b at tick %0d", o_done, exp_done, tick_n);
            end
        end
    end

    task automatic push_frame(input logic [7:0] d);
        logic p;
        p = 1'b0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(d[i]);
            p ^= d[i];
        end
`ifdef UART_TX_PARITY_EN
        exp_q.push_back(p ^ 1'(PODD));
`endif
        for (int i = 0; i < SB; i++) exp_q.push_back(1'b1);
    endtask

    task automatic send(input logic [7:0] d);
        int n = 0;
        i_data = d;
        i_valid = 1'b1;
        while (!o_ready && n < LIM) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (!o_ready) begin
            n_bad++;
            $display("FAIL send_ready: o_ready=%b required 1 for %h", o_ready, d);
        end else push_frame(d);
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || mon_idx != 0 || o_busy) && n < LIM) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n >= LIM) begin
            n_bad++;
            $display("FAIL %s_timeout: %0d bits left, busy=%b required drained and 0", nm, exp_q.size(), o_busy);
        end
        n_cmp++;
        if (o_busy !== 1'b0 || o_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_idle: busy=%b ready=%b required 0 1", nm, o_busy, o_ready);
        end
    endtask

    task automatic check_len(input string nm);
        n_cmp++;
        if (starts_q.size() != 1 || dones_q.size() != 1) begin
            n_bad++;
            $display("FAIL %s_frames: starts=%0d dones=%0d required 1 1", nm, starts_q.size(), dones_q.size());
        end else if (dones_q[0] - starts_q[0] != FL) begin
            n_bad++;
            $display("FAIL %s_len: %0d periods required %0d", nm, dones_q[0] - starts_q[0], FL);
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({o_tx, o_ready, o_busy, o_done} !== 4'b1100) begin
            n_bad++;
            $display("FAIL reset_vals: tx/ready/busy/done=%b required 1100", {o_tx, o_ready, o_busy, o_done});
        end
        i_rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_idle();
        repeat (200) begin
            @(negedge clk);
            n_cmp++;
            if ({o_tx, o_ready, o_busy} !== 3'b110) begin
                n_bad++;
                $display("FAIL idle_line: tx/ready/busy=%b required 110", {o_tx, o_ready, o_busy});
            end
        end
    endtask

    task automatic test_frame_55();
        starts_q.delete();
        dones_q.delete();
        send(8'h55);
        wait_idle("f55");
        check_len("f55");
    endtask

    task automatic test_back_to_back();
        int n = 0;
        starts_q.delete();
        dones_q.delete();
        send(8'hA3);
        i_data = 8'h0F;
        i_valid = 1'b1;
        while (!o_ready && n < LIM) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (o_ready !== 1'b1 || o_done !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_accept: ready=%b done=%b required 1 1", o_ready, o_done);
        end
        push_frame(8'h0F);
        @(negedge clk);
        i_valid = 1'b0;
        wait_idle("b2b");
        n_cmp++;
        if (starts_q.size() != 2 || dones_q.size() != 2) begin
            n_bad++;
            $display("FAIL b2b_frames: starts=%0d dones=%0d required 2 2", starts_q.size(), dones_q.size());
        end else if (starts_q[1] != dones_q[0] + 1 || dones_q[0] - starts_q[0] != FL) begin
            n_bad++;
            $display("FAIL b2b_gap: start2=%0d done1=%0d start1=%0d required start2=done1+1, len %0d",
                     starts_q[1], dones_q[0], starts_q[0], FL);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        starts_q.delete();
        dones_q.delete();
        send(8'h07);
        wait_idle("par");
        check_len("par");
    endtask
`endif

    task automatic test_reset_mid();
        int n = 0;
        send(8'hFF);
        while (mon_idx != 5 && n < LIM) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (mon_idx != 5) begin
            n_bad++;
            $display("FAIL rst_mid_reach: bit index %0d required 5", mon_idx);
        end
        repeat (3) @(negedge clk);
        i_rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({o_tx, o_ready, o_busy, o_done} !== 4'b1100) begin
            n_bad++;
            $display("FAIL rst_mid_vals: tx/ready/busy/done=%b required 1100", {o_tx, o_ready, o_busy, o_done});
        end
        repeat (3) @(negedge clk);
        i_rst_n = 1'b1;
        repeat (40) @(negedge clk);
        starts_q.delete();
        dones_q.delete();
        send(8'h81);
        wait_idle("rst81");
        check_len("rst81");
    endtask

    task automatic test_handshake();
        int   n = 0;
        logic got = 1'b0;
        logic [7:0] d;
        send(8'h3C);
        i_valid = 1'b1;
        while (!got && n < LIM) begin
            @(negedge clk);
            n++;
            d = 8'($urandom);
            i_data = d;
            if (o_ready) begin
                push_frame(d);
                got = 1'b1;
            end
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL hs_accept: o_ready=%b required 1", o_ready);
        end
        @(negedge clk);
        i_valid = 1'b0;
        repeat (100) begin
            i_data = 8'($urandom);
            @(negedge clk);
        end
        wait_idle("hs");
    endtask

    initial begin
        test_reset();
        test_idle();
        test_frame_55();
        test_back_to_back();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        test_handshake();
        repeat (20) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
